vec_mem_unit: RTL and testbench
===============================

VEC_MEM_UNIT -- requirements
Module: vec_mem_unit

Interface
REQ-001 Parameter DATA_W, default 32: width of data words, addresses and lane outputs.
REQ-002 Parameter STRIDE, default 4: byte increment between consecutive vector-lane addresses.
REQ-003 Port clk  in  1: single clock; all state updates on rising edge.
REQ-004 Port reset  in  1: synchronous, active-high reset.
REQ-005 Port start  in  1: memory operation request from the EX/MEM register.
REQ-006 Port is_store  in  1: 1 = store, 0 = load.
REQ-007 Port is_vector  in  1: 1 = 4-lane access, 0 = scalar, lane 1 only.
REQ-008 Port base_addr  in  32: byte address of lane 1.
REQ-009 Port wdata1..wdata4  in  32 each: store data for lanes 1..4.
REQ-010 Port mem_rdata  in  32: data-memory read data, valid the cycle after its address is presented.
REQ-011 Port mem_addr  out  32: data-memory address.
REQ-012 Port mem_we  out  1: data-memory write enable.
REQ-013 Port mem_wdata  out  32: data-memory write data.
REQ-014 Port busy  out  1: pipeline stall request.
REQ-015 Port done  out  1: one-cycle completion pulse.
REQ-016 Port v1mem_out..v4mem_out  out  32 each: loaded lane values, feeding the MEM/WB register.

Function
REQ-017 FSM states SHALL be IDLE, ACCESS, DRAIN.
REQ-018 In IDLE, start=1 at an edge SHALL latch is_store, is_vector, base_addr and wdata1..4, set idx=0 and enter ACCESS.
REQ-019 start SHALL be ignored in ACCESS and DRAIN; no queuing.
REQ-020 last = 3 if is_vector, else 0, using latched values.
REQ-021 In ACCESS: mem_addr = {base_addr[31:2],2'b00} + idx*STRIDE, modulo 2^32 with wrap-around, no error.
REQ-022 In ACCESS: mem_we = latched is_store, and mem_wdata = latched wdata of lane idx+1.
REQ-023 In ACCESS: idx increments each cycle.
REQ-024 In ACCESS, when idx==last: stores go to IDLE with done<=1; loads go to DRAIN.
REQ-025 On loads, each ACCESS cycle with idx>0 SHALL capture mem_rdata into lane idx (the 1-based lane of the previous address).
REQ-026 DRAIN SHALL capture mem_rdata into lane last+1, go to IDLE and set done<=1.
REQ-027 busy SHALL be 1 in ACCESS and DRAIN, and 0 in IDLE.
REQ-028 done SHALL be registered and high for exactly the first IDLE cycle after completion.
REQ-029 start in that done cycle SHALL be accepted, giving back-to-back operations.
REQ-030 Outside ACCESS: mem_we=0, mem_addr=0, mem_wdata=0.
REQ-031 Lane outputs SHALL hold their value until overwritten by a load.
REQ-032 A store SHALL leave all lane outputs unchanged.
REQ-033 A scalar load SHALL alter v1mem_out only.
REQ-034 Latency from the start-sampling edge to the done-rising edge: vector load 5, scalar load 2, vector store 4, scalar store 1 cycles.
REQ-035 Memory read data SHALL NOT be combinationally forwarded to lane outputs; lanes update only on edges.

Reset
REQ-036 reset=1 at an edge SHALL force IDLE, idx=0, done=0, busy=0, and all lanes to 0.
REQ-037 reset SHALL take priority over start and over any in-flight operation.
REQ-038 Reset mid-operation SHALL abort with no done pulse; mem_we=0 from the next cycle.

Verification
REQ-039 Vector load, base=0x100, memory[0x100..0x10C]=11,22,33,44 -> addresses 0x100,0x104,0x108,0x10C on consecutive cycles; busy 5 cycles; done pulse; lanes=11,22,33,44.
REQ-040 Vector store, base=0x200, wdata=A,B,C,D -> mem_we=1 for 4 cycles at 0x200..0x20C with A..D; lanes unchanged; done after 4 cycles.
REQ-041 Scalar load, base=0x013, memory[0x010]=0x55 -> mem_addr=0x010; only v1mem_out=0x55; done after 2 cycles.
REQ-042 Vector load, base=0xFFFFFFF8 -> addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4 (wrap).
REQ-043 start held high during busy, then asserted in the done cycle -> the second operation starts exactly once, from the done cycle.
REQ-044 reset asserted in the 3rd ACCESS cycle of a vector load -> next cycle: IDLE, busy=0, mem_we=0, all lanes 0, no done pulse.

Source files
------------

// File: rtl/vec_mem_unit.sv
// Vector/scalar memory unit: drives lanes of a 4-lane access onto a single-port data memory
// over consecutive cycles and collects load data into per-lane output registers.
module vec_mem_unit #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned STRIDE = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              is_store,
    input  logic              is_vector,
    input  logic [DATA_W-1:0] base_addr,
    input  logic [DATA_W-1:0] wdata1,
    input  logic [DATA_W-1:0] wdata2,
    input  logic [DATA_W-1:0] wdata3,
    input  logic [DATA_W-1:0] wdata4,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] v1mem_out,
    output logic [DATA_W-1:0] v2mem_out,
    output logic [DATA_W-1:0] v3mem_out,
    output logic [DATA_W-1:0] v4mem_out
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [1:0]        r_idx;
    logic              r_store;
    logic              r_vec;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_wdata [4];
    logic [DATA_W-1:0] r_lane  [4];
    logic              r_done;

    logic [1:0]        w_last;
    logic              w_at_last;
    logic [DATA_W-1:0] w_aligned;
    logic [DATA_W-1:0] w_offset;

    assign w_last    = r_vec ? 2'd3 : 2'd0;
    assign w_at_last = (r_idx == w_last);
    assign w_aligned = {r_base[DATA_W-1:2], 2'b00};
    // Product truncated to DATA_W, so lane addresses wrap modulo 2^DATA_W.
    assign w_offset  = DATA_W'(STRIDE) * DATA_W'(r_idx);

    always_comb begin
        w_next    = r_state;
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = '0;
        busy      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) w_next = ACCESS;
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_addr  = w_aligned + w_offset;
                mem_we    = r_store;
                mem_wdata = r_wdata[r_idx];
                if (w_at_last) w_next = r_store ? IDLE : DRAIN;
            end
            DRAIN: begin
                busy   = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_idx   <= '0;
            r_done  <= 1'b0;
            r_store <= 1'b0;
            r_vec   <= 1'b0;
            r_base  <= '0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_wdata[i] <= '0;
                r_lane[i]  <= '0;
            end
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_store    <= is_store;
                        r_vec      <= is_vector;
                        r_base     <= base_addr;
                        r_wdata[0] <= wdata1;
                        r_wdata[1] <= wdata2;
                        r_wdata[2] <= wdata3;
                        r_wdata[3] <= wdata4;
                        r_idx      <= '0;
                    end
                end
                ACCESS: begin
                    r_idx <= r_idx + 2'd1;
                    // Read data returned now belongs to the previous cycle's address.
                    if (!r_store && r_idx != 2'd0) r_lane[r_idx - 2'd1] <= mem_rdata;
                    if (w_at_last && r_store) r_done <= 1'b1;
                end
                DRAIN: begin
                    r_lane[w_last] <= mem_rdata;
                    r_done         <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign done      = r_done;
    assign v1mem_out = r_lane[0];
    assign v2mem_out = r_lane[1];
    assign v3mem_out = r_lane[2];
    assign v4mem_out = r_lane[3];

endmodule

// File: tb/tb_vec_mem_unit.sv
// Bench for vec_mem_unit: transaction-level model plus memory, checked every cycle,
// with directed literal scenarios followed by randomized traffic.
module tb_vec_mem_unit;
    localparam int unsigned STRIDE = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1, start = 1'b0, is_store = 1'b0, is_vector = 1'b0;
    logic [31:0] base_addr = '0, wdata1 = '0, wdata2 = '0, wdata3 = '0, wdata4 = '0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] mem_addr, mem_wdata, v1mem_out, v2mem_out, v3mem_out, v4mem_out;
    logic        mem_we, busy, done;

    vec_mem_unit #(.DATA_W(32), .STRIDE(STRIDE)) dut (
        .clk(clk), .reset(reset), .start(start), .is_store(is_store), .is_vector(is_vector),
        .base_addr(base_addr), .wdata1(wdata1), .wdata2(wdata2), .wdata3(wdata3),
        .wdata4(wdata4), .mem_rdata(mem_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .busy(busy), .done(done), .v1mem_out(v1mem_out),
        .v2mem_out(v2mem_out), .v3mem_out(v3mem_out), .v4mem_out(v4mem_out)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory: unwritten words read back as an address-derived pattern.
    logic [31:0] mem [logic [31:0]];
    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'hC0DE_0000;
    endfunction

    // Transaction model: one op = a fixed list of cycles derived from its parameters.
    bit          m_active = 0, m_store = 0, m_done = 0, m_was = 0;
    int          m_cyc = 0, m_last = 0, m_len = 0;
    logic [31:0] m_base4 = '0;
    logic [31:0] m_wd [4];
    logic [31:0] m_ld [4];
    logic [31:0] m_lanes [4] = '{default: '0};

    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] = mem_wdata;
        mem_rdata <= rd(mem_addr);
        if (reset) begin
            m_active = 0;
            m_done   = 0;
            for (int j = 0; j < 4; j++) m_lanes[j] = '0;
        end else begin
            m_was  = m_active;
            m_done = 0;
            if (m_active) begin
                m_cyc++;
                if (m_cyc == m_len) begin
                    m_active = 0;
                    m_done   = 1;
                    if (!m_store) for (int j = 0; j <= m_last; j++) m_lanes[j] = m_ld[j];
                end
            end
            if (!m_was && start) begin
                m_base4 = base_addr & ~32'h3;
                m_store = is_store;
                m_last  = is_vector ? 3 : 0;
                m_len   = m_last + 1 + (is_store ? 0 : 1);
                m_wd    = '{wdata1, wdata2, wdata3, wdata4};
                for (int j = 0; j <= m_last; j++) m_ld[j] = rd(m_base4 + 32'(j * STRIDE));
                m_cyc    = 0;
                m_active = 1;
            end
        end
    end

    bit          chk_en = 0;
    logic [31:0] e_addr, e_wd;
    logic        e_we, e_busy, e_done;
    logic [31:0] e_l [4];

    always @(negedge clk) begin
        if (chk_en) begin
            e_addr = '0; e_wd = '0; e_we = 0; e_busy = 0; e_done = m_done;
            e_l = m_lanes;
            if (m_active) begin
                e_busy = 1;
                e_done = 0;
                if (m_cyc <= m_last) begin
                    e_addr = m_base4 + 32'(m_cyc * STRIDE);
                    e_we   = m_store;
                    e_wd   = m_wd[m_cyc];
                end
                // Lane k (0-based) becomes visible two cycles after its address was driven.
                if (!m_store)
                    for (int j = 0; j <= m_last; j++) if (m_cyc >= j + 2) e_l[j] = m_ld[j];
            end
            check("mem_addr", mem_addr, e_addr);
            check("mem_we", {31'b0, mem_we}, {31'b0, e_we});
            check("mem_wdata", mem_wdata, e_wd);
            check("busy", {31'b0, busy}, {31'b0, e_busy});
            check("done", {31'b0, done}, {31'b0, e_done});
            check("v1", v1mem_out, e_l[0]);
            check("v2", v2mem_out, e_l[1]);
            check("v3", v3mem_out, e_l[2]);
            check("v4", v4mem_out, e_l[3]);
        end
    end

    task automatic drive(input bit st, input bit vec, input logic [31:0] b,
                         input logic [31:0] a, input logic [31:0] bb,
                         input logic [31:0] c, input logic [31:0] d);
        start = 1; is_store = st; is_vector = vec; base_addr = b;
        wdata1 = a; wdata2 = bb; wdata3 = c; wdata4 = d;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'b0, done}, 32'd1);
    endtask

    int dcount;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_v1", v1mem_out, 32'd0);
        check("rst_v4", v4mem_out, 32'd0);
        chk_en = 1;
        #1 reset = 0;

        // Vector load at 0x100
        mem[32'h100] = 32'd11; mem[32'h104] = 32'd22;
        mem[32'h108] = 32'd33; mem[32'h10C] = 32'd44;
        mem[32'h010] = 32'h55;
        drive(0, 1, 32'h100, '0, '0, '0, '0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("vld_addr", mem_addr, 32'h100 + 32'(4 * k));
            check("vld_busy", {31'b0, busy}, 32'd1);
            if (k == 0) #1 start = 0;
        end
        @(negedge clk);
        check("vld_drain_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("vld_done", {31'b0, done}, 32'd1);
        check("vld_v1", v1mem_out, 32'd11);
        check("vld_v2", v2mem_out, 32'd22);
        check("vld_v3", v3mem_out, 32'd33);
        check("vld_v4", v4mem_out, 32'd44);

        // Scalar load at 0x013 issued in the done cycle
        #1 drive(0, 0, 32'h13, '0, '0, '0, '0);
        @(negedge clk);
        check("sld_addr", mem_addr, 32'h10);
        #1 start = 0;
        @(negedge clk);
        check("sld_drain_busy", {31'b0, busy}, 32'd1);
        @(negedge clk);
        check("sld_done", {31'b0, done}, 32'd1);
        check("sld_v1", v1mem_out, 32'h55);
        check("sld_v2", v2mem_out, 32'd22);

        // Vector store at 0x200
        #1 drive(1, 1, 32'h200, 32'hA, 32'hB, 32'hC, 32'hD);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("vst_addr", mem_addr, 32'h200 + 32'(4 * k));
            check("vst_we", {31'b0, mem_we}, 32'd1);
            check("vst_wdata", mem_wdata, 32'hA + 32'(k));
            if (k == 0) #1 start = 0;
        end
        @(negedge clk);
        check("vst_done", {31'b0, done}, 32'd1);
        check("vst_v1", v1mem_out, 32'h55);
        check("vst_v4", v4mem_out, 32'd44);

        // Address wrap
        #1 drive(0, 1, 32'hFFFF_FFF8, '0, '0, '0, '0);
        @(negedge clk); check("wrap_a0", mem_addr, 32'hFFFF_FFF8);
        #1 start = 0;
        @(negedge clk); check("wrap_a1", mem_addr, 32'hFFFF_FFFC);
        @(negedge clk); check("wrap_a2", mem_addr, 32'h0);
        @(negedge clk); check("wrap_a3", mem_addr, 32'h4);
        wait_done("wrap_done_timeout");

        // start held high: scalar stores repeat every two cycles
        @(negedge clk);
        #1 drive(1, 0, 32'h500, 32'h77, '0, '0, '0);
        dcount = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) dcount++;
        end
        check("held_start_dones", 32'(dcount), 32'd4);
        #1 start = 0;
        repeat (2) @(negedge clk);

        // Reset in the third ACCESS cycle of a vector load
        #1 drive(0, 1, 32'h300, '0, '0, '0, '0);
        @(negedge clk);
        #1 start = 0;
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1;
        @(negedge clk);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_we", {31'b0, mem_we}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_v1", v1mem_out, 32'd0);
        check("abort_v4", v4mem_out, 32'd0);
        #1 reset = 0;
        @(negedge clk);
        check("abort_no_done", {31'b0, done}, 32'd0);

        // Randomized traffic
        repeat (600) begin
            @(negedge clk);
            #1;
            reset = ($urandom_range(0, 80) == 0);
            case ($urandom_range(0, 2))
                0: base_addr = 32'h400 + 32'($urandom_range(0, 63));
                1: base_addr = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
                default: base_addr = $urandom;
            endcase
            start     = ($urandom_range(0, 2) == 0);
            is_store  = $urandom_range(0, 1) == 1;
            is_vector = $urandom_range(0, 1) == 1;
            wdata1 = $urandom; wdata2 = $urandom; wdata3 = $urandom; wdata4 = $urandom;
        end
        #1 reset = 0; start = 0;
        repeat (10) @(negedge clk);
        check("final_idle", {31'b0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
